// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths, types and byte-lane merge for the register file
// Imported by reg_file and reg_file_rport.
package reg_file_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_BE_W   = REG_DATA_W / 8;
  localparam int REG_NUM    = 2 ** REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [REG_BE_W-1:0]   reg_be_t;

  // Enabled lanes take the new word, disabled lanes keep the old one.
  function automatic reg_data_t be_merge(input reg_data_t old_w,
                                         input reg_data_t new_w,
                                         input reg_be_t   be);
    reg_data_t res;
    res = old_w;
    for (int b = 0; b < REG_BE_W; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file_rport.sv
// rtl/reg_file_rport.sv - one combinational read port: array select, zero register, bypass
// Bypass ports and merge exist only when REG_FILE_BYPASS_EN is defined.
module reg_file_rport
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic [ADDR_W-1:0]   i_rr,
  input  logic [DATA_W-1:0]   i_mem [2**ADDR_W],
`ifdef REG_FILE_BYPASS_EN
  input  logic                i_rst_n,
  input  logic [ADDR_W-1:0]   i_wr,
  input  logic [DATA_W-1:0]   i_wd,
  input  logic [DATA_W/8-1:0] i_we,
`endif
  output logic [DATA_W-1:0]   o_rd
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] w_rd;

  always_comb begin
    w_rd = i_mem[i_rr];
`ifdef REG_FILE_BYPASS_EN
    // i_rr == i_wr with i_rr != 0 below already implies a nonzero write address.
    if (i_rst_n && (i_wr == i_rr)) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_we[b]) w_rd[8*b +: 8] = i_wd[8*b +: 8];
      end
    end
`endif
    if (i_rr == '0) w_rd = '0;
  end

  assign o_rd = w_rd;

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two async reads, one byte-enabled sync write
// Optional write-to-read forwarding: define REG_FILE_BYPASS_EN.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W/8-1:0] reg_we,
  input  logic [ADDR_W-1:0]   RR1,
  input  logic [ADDR_W-1:0]   RR2,
  input  logic [ADDR_W-1:0]   WR,
  input  logic [DATA_W-1:0]   WD,
  output logic [DATA_W-1:0]   RD1,
  output logic [DATA_W-1:0]   RD2
);

  localparam int BE_W = DATA_W / 8;
  localparam int NUM  = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [NUM];
  logic              w_wr_en;

  assign w_wr_en = (WR != '0) && (reg_we != '0);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (reg_we[b]) r_mem[WR][8*b +: 8] <= WD[8*b +: 8];
      end
    end
  end

  reg_file_rport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rport1 (
    .i_rr   (RR1),
    .i_mem  (r_mem),
`ifdef REG_FILE_BYPASS_EN
    .i_rst_n(rst_n),
    .i_wr   (WR),
    .i_wd   (WD),
    .i_we   (reg_we),
`endif
    .o_rd   (RD1)
  );

  reg_file_rport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rport2 (
    .i_rr   (RR2),
    .i_mem  (r_mem),
`ifdef REG_FILE_BYPASS_EN
    .i_rst_n(rst_n),
    .i_wr   (WR),
    .i_wd   (WD),
    .i_we   (reg_we),
`endif
    .o_rd   (RD2)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed and randomized checks of reg_file against an array model
// Expectations follow REG_FILE_BYPASS_EN when the bench is built with it.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [3:0]  reg_we;
  logic [4:0]  RR1, RR2, WR;
  logic [31:0] WD;
  logic [31:0] RD1, RD2;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] model [32];

  reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .reg_we(reg_we),
    .RR1   (RR1),
    .RR2   (RR2),
    .WR    (WR),
    .WD    (WD),
    .RD1   (RD1),
    .RD2   (RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] merged(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] be);
    return (new_v & lane_mask(be)) | (old_v & ~lane_mask(be));
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] rr);
    logic [31:0] v;
    if (rr == 5'd0 || !rst_n) return 32'h0;
    v = model[rr];
`ifdef REG_FILE_BYPASS_EN
    if (WR == rr) v = merged(v, WD, reg_we);
`endif
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Called right after a rising edge, with inputs still as they were at the edge.
  task automatic model_edge();
    if (rst_n && WR != 5'd0) model[WR] = merged(model[WR], WD, reg_we);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    WR = a; WD = d; reg_we = be;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    reg_we = 4'h0;
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0; WR = 5'd1; WD = 32'h11111111; reg_we = 4'hF; RR1 = 5'd1; RR2 = 5'd1;
    #22;
    chk("reset_hold_rd1", RD1, 32'h0);
    chk("reset_hold_rd2", RD2, 32'h0);
    @(negedge clk);
    reg_we = 4'h0;
    rst_n = 1'b1;

    wr(5'd1, 32'h11111111, 4'hF);
    chk("full_write_1", RD1, 32'h11111111);
    wr(5'd1, 32'h22222222, 4'hF);
    chk("full_write_2", RD1, 32'h22222222);

    RR1 = 5'd3;
    wr(5'd3, 32'hAABBCCDD, 4'hF);
    wr(5'd3, 32'h11223344, 4'b0101);
    chk("byte_lanes_0101", RD1, 32'hAA22CC44);
    wr(5'd3, 32'h55667788, 4'b0000);
    chk("byte_lanes_0000", RD1, 32'hAA22CC44);

    RR1 = 5'd0; RR2 = 5'd0;
    wr(5'd0, 32'hFFFFFFFF, 4'hF);
    chk("zero_reg_rd1", RD1, 32'h0);
    chk("zero_reg_rd2", RD2, 32'h0);

    wr(5'd5, 32'h12345678, 4'hF);
    wr(5'd7, 32'h9ABCDEF0, 4'hF);
    RR1 = 5'd5; RR2 = 5'd7;
    #1;
    chk("dual_read_rd1", RD1, 32'h12345678);
    chk("dual_read_rd2", RD2, 32'h9ABCDEF0);
    WR = 5'd5; WD = 32'hDEADBEEF; reg_we = 4'hF;
    #1 rst_n = 1'b0;
    clear_model();
    #1;
    chk("async_rst_rd1", RD1, 32'h0);
    chk("async_rst_rd2", RD2, 32'h0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("rst_drops_write", RD1, 32'h0);
    reg_we = 4'h0;
    rst_n = 1'b1;
    #1 chk("after_release_rd2", RD2, 32'h0);

    wr(5'd9, 32'h1, 4'hF);
    RR1 = 5'd9; WR = 5'd9; WD = 32'h2; reg_we = 4'hF;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("same_cycle_before", RD1, 32'h2);
`else
    chk("same_cycle_before", RD1, 32'h1);
`endif
    @(posedge clk);
    model_edge();
    @(negedge clk);
    reg_we = 4'h0;
    chk("same_cycle_after", RD1, 32'h2);

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst_n  = 1'b1;
      WR     = 5'($urandom_range(0, 31));
      WD     = $urandom;
      reg_we = 4'($urandom);
      RR1    = ($urandom_range(0, 3) == 0) ? WR : 5'($urandom_range(0, 31));
      RR2    = ($urandom_range(0, 3) == 0) ? WR : 5'($urandom_range(0, 31));
      #1;
      chk("rand_rd1", RD1, exp_rd(RR1));
      chk("rand_rd2", RD2, exp_rd(RR2));
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("rand_rst_rd1", RD1, 32'h0);
      end
      @(posedge clk);
      model_edge();
    end

    @(negedge clk);
    reg_we = 4'h0;
    for (int i = 0; i < 32; i++) begin
      RR1 = 5'(i);
      RR2 = 5'(31 - i);
      #1;
      chk("final_rd1", RD1, exp_rd(RR1));
      chk("final_rd2", RD2, exp_rd(RR2));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
